fm0_encoder: RTL and testbench

//  Tag-side FM0 backscatter encoder; consumer of the /4 divided clock. The divided clock is sampled in
//  the clk_in domain, never used as a clock; its rising edges are half-bit ticks. Accepts one WIDTH-bit

---
 rtl/rfid_pkg.sv | 18 +
 rtl/rise_detect.sv | 22 ++
 rtl/fm0_encoder.sv | 128 ++++++++++++
 tb/tb_fm0_encoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rfid_pkg.sv
// rtl/rfid_pkg.sv - shared FM0 encoder types and constants
`timescale 1ns/1ps
package rfid_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DUMMY    = 2'd3
  } fm0_state_t;

  // Half-bit levels of the FM0 preamble, sent MSB first.
  localparam logic [11:0] FM0_PREAMBLE_HB = 12'b110100100011;

  // The tick source is the system clock divided by this value.
  localparam int FM0_TICK_DIV = 4;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector for a same-domain strobe
`timescale 1ns/1ps
module rise_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_in,
  output logic rise_out
);

  logic sig_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_in;
    end
  end

  assign rise_out = sig_in & ~sig_q;

endmodule

// File: rtl/fm0_encoder.sv
// rtl/fm0_encoder.sv - FM0 backscatter encoder driven by half-bit ticks; FM0_PREAMBLE_EN adds the preamble
`timescale 1ns/1ps
module fm0_encoder
  import rfid_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             div_clk_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid_in,
  output logic             data_ready_out,
  output logic             tx_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int BW = $clog2(WIDTH + 1);

  fm0_state_t       state;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    bit_cnt;
  logic             half_q;
  logic             dummy_sent_q;
  logic             tick;
`ifdef FM0_PREAMBLE_EN
  logic [3:0]       pre_cnt;
`endif

  rise_detect u_tick (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sig_in   (div_clk_in),
    .rise_out (tick)
  );

  assign data_ready_out = (state == IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      tx_out       <= 1'b0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      shift_q      <= '0;
      bit_cnt      <= '0;
      half_q       <= 1'b0;
      dummy_sent_q <= 1'b0;
`ifdef FM0_PREAMBLE_EN
      pre_cnt      <= '0;
`endif
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          // A tick coinciding with accept is deliberately not consumed.
          if (data_valid_in) begin
            shift_q      <= data_in;
            bit_cnt      <= BW'(WIDTH);
            half_q       <= 1'b0;
            dummy_sent_q <= 1'b0;
            busy_out     <= 1'b1;
`ifdef FM0_PREAMBLE_EN
            pre_cnt      <= '0;
            state        <= PREAMBLE;
`else
            state        <= DATA;
`endif
          end
        end
`ifdef FM0_PREAMBLE_EN
        PREAMBLE: begin
          if (tick) begin
            tx_out <= FM0_PREAMBLE_HB[4'd11 - pre_cnt];
            if (pre_cnt == 4'd11) begin
              pre_cnt <= '0;
              state   <= DATA;
            end else begin
              pre_cnt <= pre_cnt + 4'd1;
            end
          end
        end
`endif
        DATA: begin
          if (tick) begin
            if (!half_q) begin
              tx_out <= ~tx_out;
              half_q <= 1'b1;
            end else begin
              // Mid-bit inversion encodes a zero.
              if (!shift_q[WIDTH-1]) begin
                tx_out <= ~tx_out;
              end
              half_q  <= 1'b0;
              shift_q <= shift_q << 1;
              bit_cnt <= bit_cnt - BW'(1);
              if (bit_cnt == BW'(1)) begin
                state <= DUMMY;
              end
            end
          end
        end
        DUMMY: begin
          if (tick) begin
            if (dummy_sent_q) begin
              tx_out       <= 1'b0;
              busy_out     <= 1'b0;
              done_out     <= 1'b1;
              dummy_sent_q <= 1'b0;
              state        <= IDLE;
            end else if (!half_q) begin
              tx_out <= ~tx_out;
              half_q <= 1'b1;
            end else begin
              half_q       <= 1'b0;
              dummy_sent_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fm0_encoder.sv
// tb/tb_fm0_encoder.sv - randomized self-checking bench for fm0_encoder (WIDTH=8)
`timescale 1ns/1ps
module tb_fm0_encoder;
  import rfid_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         data_valid_in = 1'b0;
  logic         data_ready_out, tx_out, busy_out, done_out;
  logic         div_hold = 1'b0;
  logic         div_clk_in;
  int           div_cnt = 0;
  logic         div_prev = 1'b0;
  logic         tb_tick = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  logic exp_q[$];

  fm0_encoder #(.WIDTH(W)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .div_clk_in     (div_clk_in),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
    .data_ready_out (data_ready_out),
    .tx_out         (tx_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!div_hold) div_cnt <= div_cnt + 1;
  assign div_clk_in = !div_hold && ((div_cnt % FM0_TICK_DIV) >= FM0_TICK_DIV / 2);

  always @(posedge clk) begin
    tb_tick  <= div_clk_in & ~div_prev;
    div_prev <= div_clk_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  // Reference: FM0 half-bit levels derived from the encoding rules.
  task automatic build_expected(input logic [W-1:0] w);
    logic lvl;
    logic b;
    logic [11:0] hb;
    exp_q.delete();
    lvl = 1'b0;
`ifdef FM0_PREAMBLE_EN
    hb = FM0_PREAMBLE_HB;
    for (int i = 11; i >= 0; i--) begin
      lvl = hb[i];
      exp_q.push_back(lvl);
    end
`endif
    for (int i = W; i >= 0; i--) begin
      b = (i == 0) ? 1'b1 : w[i-1];
      lvl = ~lvl;
      exp_q.push_back(lvl);
      if (!b) lvl = ~lvl;
      exp_q.push_back(lvl);
    end
    exp_q.push_back(1'b0);
  endtask

  task automatic accept(input logic [W-1:0] w, input bit keep_valid);
    @(negedge clk);
    data_in = w;
    data_valid_in = 1'b1;
    @(posedge clk); #1;
    check("accept_busy", busy_out, 1);
    check("accept_ready", data_ready_out, 0);
    if (!keep_valid) data_valid_in = 1'b0;
  endtask

  task automatic watch(input logic [W-1:0] w, input int stall_at, input int abort_at, input bit keep_valid);
    int idx;
    int cyc;
    logic lvl;
    build_expected(w);
    idx = 0;
    cyc = 0;
    lvl = 1'b0;
    while (idx < exp_q.size() && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (tb_tick) begin
        check($sformatf("tx_tick%0d", idx), tx_out, exp_q[idx]);
        lvl = exp_q[idx];
        idx++;
        if (idx == exp_q.size()) begin
          check("done_last", done_out, 1);
          check("busy_last", busy_out, 0);
          check("ready_last", data_ready_out, 1);
        end else begin
          check("done_mid", done_out, 0);
          check("busy_mid", busy_out, 1);
        end
        if (idx == abort_at) begin
          @(negedge clk);
          rst = 1'b1;
          @(posedge clk); #1;
          check("abort_tx", tx_out, 0);
          check("abort_busy", busy_out, 0);
          check("abort_ready", data_ready_out, 1);
          check("abort_done", done_out, 0);
          rst = 1'b0;
          repeat (40) begin
            @(posedge clk); #1;
            check("abort_no_done", done_out, 0);
          end
          check("abort_idle_tx", tx_out, 0);
          return;
        end
        if (idx == stall_at) begin
          div_hold = 1'b1;
          repeat (50) begin
            @(posedge clk); #1;
            check("stall_tx", tx_out, lvl);
          end
          check("stall_busy", busy_out, 1);
          div_hold = 1'b0;
        end
      end else begin
        check("tx_hold", tx_out, lvl);
      end
    end
    if (cyc >= 2000) check("frame_timeout", 0, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done_out, 0);
    check("busy_after", busy_out, keep_valid);
  endtask

  initial begin
    logic [W-1:0] w;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_ready", data_ready_out, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    accept(8'hA5, 0); watch(8'hA5, 0, 0, 0);
    accept(8'h00, 0); watch(8'h00, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      w = W'($urandom);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      accept(w, 0);
      watch(w, 0, 0, 0);
    end
    accept(8'h5C, 0); watch(8'h5C, 5, 0, 0);
    accept(8'hA5, 0); watch(8'hA5, 0, 7, 0);

    // Valid held high: second word taken as soon as the line is idle again.
    accept(8'hA5, 1);
    data_in = 8'hFF;
    watch(8'hA5, 0, 0, 1);
    check("hs2_ready", data_ready_out, 0);
    data_valid_in = 1'b0;
    watch(8'hFF, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
